pixel_row_packer: RTL and testbench
===================================

# pixel_row_packer

Serial-to-row packer that builds the 70-pixel row word consumed by the denoise front end. Accepts one 8-bit pixel per cycle under a valid/ready handshake, assembles `ROW_PIX` pixels into a `BIT_WIDTH*ROW_PIX`-bit row, and presents completed rows with a row index under a second valid/ready handshake. Sits between the external pixel source and the row-wide input register ahead of denoise; tracks a `FRAME_ROWS`-row frame.

## Interface
- `BIT_WIDTH`, 8, bits per pixel
- `ROW_PIX`, 70, pixels per row
- `FRAME_ROWS`, 160, rows per frame
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `pix_valid`  in  1  pixel offered
- `pix_data`  in  BIT_WIDTH  pixel value
- `pix_sof`  in  1  qualifies `pix_valid`: this pixel is frame pixel (row 0, col 0)
- `pix_ready`  out  1  packer accepts pixel this cycle
- `row_valid`  out  1  completed row presented
- `row_out`  out  BIT_WIDTH*ROW_PIX  row word; pixel k in bits [BIT_WIDTH*k+BIT_WIDTH-1 : BIT_WIDTH*k]
- `row_idx`  out  8  row number of `row_out`, 0..FRAME_ROWS-1
- `row_last`  out  1  `row_idx == FRAME_ROWS-1`, valid with `row_valid`
- `row_ready`  in  1  consumer takes row this cycle
- `frame_done`  out  1  one-cycle pulse after last row of a frame transferred
- `sync_err`  out  1  sticky: `pix_sof` seen mid-row or mid-frame

## Operation
- Pixel accept = `pix_valid && pix_ready`; row transfer = `row_valid && row_ready`.
- Two row buffers (ping-pong), each with full flag and stored row index. Write pointer `wr_sel`, read pointer `rd_sel`, column counter `col` (0..ROW_PIX-1), row counter `wr_row` (0..FRAME_ROWS-1).
- `pix_ready = !full[wr_sel]`; purely register-derived, no combinational path from `row_ready`.
- On accept: pixel written to buffer `wr_sel` at slot `col`; `col` increments. At `col == ROW_PIX-1`: `col`←0, `full[wr_sel]`←1, stored index←`wr_row`, `wr_sel` toggles, `wr_row` increments, wrapping FRAME_ROWS-1→0.
- `row_valid = full[rd_sel]`; `row_out`/`row_idx` driven from buffer `rd_sel`. On transfer: `full[rd_sel]`←0, `rd_sel` toggles; if transferred index == FRAME_ROWS-1, `frame_done` pulses next cycle.
- Fill-complete and transfer in same cycle act on different buffers; both take effect.
- `pix_sof` on accept: if `col==0 && wr_row==0`, normal. Otherwise: partial row in buffer `wr_sel` discarded, pixel stored at slot 0, `col`←1, `wr_row`←0, `sync_err`←1. Already-full buffers untouched and still delivered.
- `pix_sof` without `pix_valid` ignored. `pix_data` ignored when not accepted.
- `sync_err` clears only on reset.

## Timing
- Reset (async assert, sync release): `col`, `wr_row`, `wr_sel`, `rd_sel`, full flags, buffers, `row_out`, `row_idx`, `row_last`, `row_valid`, `frame_done`, `sync_err` all 0; `pix_ready` 1 in first cycle after release.
- Latency: last pixel accepted at edge t → `row_valid` high after edge t, i.e. usable at edge t+1.
- `row_out`, `row_idx`, `row_last` stable while `row_valid && !row_ready`.
- Sustained throughput with `row_ready` held high: one pixel per cycle, no bubbles; a row every ROW_PIX cycles.
- Backpressure: both buffers full → `pix_ready` low until next transfer; rises the cycle after transfer.
- Reset mid-row or mid-frame: partial row and pending rows discarded, no `row_valid` or `frame_done` emitted.

## Configuration
- `PIXEL_ROW_PACKER_PINGPONG_EN` defined: two buffers as above.
- Undefined: single buffer; `wr_sel`/`rd_sel` fixed at 0; `pix_ready` low from row completion until the cycle after its transfer (one-cycle bubble per row minimum). All other behaviour, including SOF resync and indexing, identical.

## Test plan
- Reset, stream 70 pixels value k (k=0..69) with `row_ready`=1 → `row_valid` one cycle after 70th accept, `row_out` byte k == k, `row_idx`=0, `pix_ready` never low.
- Stream 160 rows back-to-back with `row_ready`=1, first pixel with `pix_sof` → row_idx 0..159 in order, `row_last` only on 159, single `frame_done` pulse, row_idx wraps to 0 on next frame.
- Hold `row_ready`=0 for 3 rows → `pix_ready` drops after 2nd row completes (after 1st with macro undefined); release → rows 0,1 delivered in order, data intact, stable while stalled.
- Assert `pix_sof` at col 35 of row 4 → `sync_err`=1, partial row dropped, next completed row has `row_idx`=0 and contains SOF pixel in byte 0.
- Toggle `pix_valid` randomly 50% and `row_ready` randomly 50% over 2 frames → scoreboard matches every row, no loss or duplication.
- Assert `rst_n` low mid-row with one row pending → all outputs 0 immediately, `pix_ready`=1 after release, pending row never presented.

Source files
------------

// File: rtl/pixel_row_packer.sv
// Serial pixel to row-word packer with frame row indexing and SOF resynchronisation.
// Define PIXEL_ROW_PACKER_PINGPONG_EN for two ping-pong row buffers; otherwise one buffer is used.
module pixel_row_packer #(
    parameter int unsigned BIT_WIDTH  = 8,
    parameter int unsigned ROW_PIX    = 70,
    parameter int unsigned FRAME_ROWS = 160
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         pix_valid,
    input  logic [BIT_WIDTH-1:0]         pix_data,
    input  logic                         pix_sof,
    output logic                         pix_ready,
    output logic                         row_valid,
    output logic [BIT_WIDTH*ROW_PIX-1:0] row_out,
    output logic [7:0]                   row_idx,
    output logic                         row_last,
    input  logic                         row_ready,
    output logic                         frame_done,
    output logic                         sync_err
);

    localparam int unsigned RowW = BIT_WIDTH * ROW_PIX;
    localparam int unsigned ColW = (ROW_PIX > 1) ? $clog2(ROW_PIX) : 1;
    localparam logic [ColW-1:0] ColLast = ColW'(ROW_PIX - 1);
    localparam logic [7:0] RowLast = 8'(FRAME_ROWS - 1);

    logic [RowW-1:0] row_buf_q [2];
    logic [7:0]      buf_idx_q [2];
    logic [1:0]      full_q, full_d;
    logic [ColW-1:0] col_q, col_d;
    logic [7:0]      wr_row_q, wr_row_d;
    logic            frame_done_q, frame_done_d;
    logic            sync_err_q, sync_err_d;

    logic            wr_sel, rd_sel;
    logic            accept, xfer, sof_resync, row_fill;
    logic [ColW-1:0] wr_slot;

`ifdef PIXEL_ROW_PACKER_PINGPONG_EN
    logic wr_sel_q, rd_sel_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
        end else begin
            if (row_fill) wr_sel_q <= ~wr_sel_q;
            if (xfer)     rd_sel_q <= ~rd_sel_q;
        end
    end

    assign wr_sel = wr_sel_q;
    assign rd_sel = rd_sel_q;
`else
    assign wr_sel = 1'b0;
    assign rd_sel = 1'b0;
`endif

    always_comb begin
        pix_ready  = !full_q[wr_sel];
        row_valid  = full_q[rd_sel];
        accept     = pix_valid && pix_ready;
        xfer       = row_valid && row_ready;
        // SOF anywhere but the very first frame pixel restarts the frame at row 0, col 0.
        sof_resync = accept && pix_sof && !((col_q == '0) && (wr_row_q == '0));
        row_fill   = accept && !sof_resync && (col_q == ColLast);
        wr_slot    = sof_resync ? '0 : col_q;

        col_d        = col_q;
        wr_row_d     = wr_row_q;
        full_d       = full_q;
        sync_err_d   = sync_err_q | sof_resync;
        frame_done_d = xfer && (buf_idx_q[rd_sel] == RowLast);

        if (sof_resync) begin
            col_d    = ColW'(1);
            wr_row_d = '0;
        end else if (row_fill) begin
            col_d    = '0;
            wr_row_d = (wr_row_q == RowLast) ? '0 : wr_row_q + 8'd1;
        end else if (accept) begin
            col_d = col_q + ColW'(1);
        end

        // Fill and transfer target different buffers whenever both happen together.
        if (xfer)     full_d[rd_sel] = 1'b0;
        if (row_fill) full_d[wr_sel] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q       <= '0;
            col_q        <= '0;
            wr_row_q     <= '0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            full_q       <= full_d;
            col_q        <= col_d;
            wr_row_q     <= wr_row_d;
            frame_done_q <= frame_done_d;
            sync_err_q   <= sync_err_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                row_buf_q[i] <= '0;
                buf_idx_q[i] <= '0;
            end
        end else begin
            if (accept) row_buf_q[wr_sel][wr_slot*BIT_WIDTH +: BIT_WIDTH] <= pix_data;
            if (row_fill) buf_idx_q[wr_sel] <= wr_row_q;
        end
    end

    assign row_out    = row_buf_q[rd_sel];
    assign row_idx    = buf_idx_q[rd_sel];
    assign row_last   = (buf_idx_q[rd_sel] == RowLast);
    assign frame_done = frame_done_q;
    assign sync_err   = sync_err_q;

    // A presented row must not change until the consumer takes it.
    assert property (@(posedge clk) disable iff (!rst_n)
        row_valid && !row_ready |=> row_valid && $stable(row_out) && $stable(row_idx));

endmodule

// File: tb/tb_pixel_row_packer.sv
// Self-checking bench for pixel_row_packer: queue-based row model plus directed scenarios.
// Follows PIXEL_ROW_PACKER_PINGPONG_EN to pick the expected buffer count.
module tb_pixel_row_packer;

    localparam int BW = 8;
    localparam int RP = 70;
    localparam int FR = 160;
    localparam int RW = BW * RP;
`ifdef PIXEL_ROW_PACKER_PINGPONG_EN
    localparam int NBUF = 2;
`else
    localparam int NBUF = 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pix_valid = 1'b0;
    logic [BW-1:0] pix_data = '0;
    logic          pix_sof = 1'b0;
    logic          row_ready = 1'b0;
    logic          pix_ready, row_valid, row_last, frame_done, sync_err;
    logic [RW-1:0] row_out;
    logic [7:0]    row_idx;

    pixel_row_packer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .pix_sof    (pix_sof),
        .pix_ready  (pix_ready),
        .row_valid  (row_valid),
        .row_out    (row_out),
        .row_idx    (row_idx),
        .row_last   (row_last),
        .row_ready  (row_ready),
        .frame_done (frame_done),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [RW-1:0] data;
        int            idx;
    } row_t;

    row_t          exp_q[$];
    logic [RW-1:0] got_data[$];
    int            got_idx[$];
    logic [RW-1:0] m_part;
    int            m_col, m_row;
    logic          m_err, m_fd;
    int            n_chk = 0, n_fail = 0;
    int            fd_count, last_count;
    logic          saw_stall;
    logic          rand_rr = 1'b0;

    task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Model: row contents follow from accepted pixels; ready/valid follow from queue occupancy.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_row_valid", row_valid, 0);
            chk("rst_row_out", row_out, 0);
            chk("rst_row_idx", row_idx, 0);
            chk("rst_frame_done", frame_done, 0);
            chk("rst_sync_err", sync_err, 0);
            exp_q.delete();
            m_part = '0;
            m_col  = 0;
            m_row  = 0;
            m_err  = 1'b0;
            m_fd   = 1'b0;
        end else begin
            chk("pix_ready", pix_ready, exp_q.size() < NBUF);
            chk("row_valid", row_valid, exp_q.size() > 0);
            chk("frame_done", frame_done, m_fd);
            chk("sync_err", sync_err, m_err);
            if (row_valid && exp_q.size() > 0) begin
                chk("row_out", row_out, exp_q[0].data);
                chk("row_idx", row_idx, exp_q[0].idx);
                chk("row_last", row_last, exp_q[0].idx == FR - 1);
            end
            if (frame_done) fd_count++;
            if (pix_valid && !pix_ready) saw_stall = 1'b1;
            m_fd = 1'b0;
            if (row_valid && row_ready && exp_q.size() > 0) begin
                got_data.push_back(row_out);
                got_idx.push_back(int'(row_idx));
                if (row_last) last_count++;
                m_fd = (exp_q[0].idx == FR - 1);
                void'(exp_q.pop_front());
            end
            if (pix_valid && pix_ready) begin
                if (pix_sof && !(m_col == 0 && m_row == 0)) begin
                    m_part       = '0;
                    m_part[7:0]  = pix_data;
                    m_col        = 1;
                    m_row        = 0;
                    m_err        = 1'b1;
                end else begin
                    m_part[m_col*BW +: BW] = pix_data;
                    m_col++;
                    if (m_col == RP) begin
                        exp_q.push_back('{data: m_part, idx: m_row});
                        m_col = 0;
                        m_row = (m_row + 1) % FR;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rr) row_ready = ($urandom_range(1, 0) == 1);
    endtask

    task automatic push(input logic [BW-1:0] d, input logic s);
        logic ok;
        int   n;
        n = 0;
        pix_valid = 1'b1;
        pix_data  = d;
        pix_sof   = s;
        do begin
            @(negedge clk);
            ok = pix_ready;
            tick();
            n++;
        end while (!ok && n < 3000);
        if (!ok) begin
            n_chk++;
            n_fail++;
            $display("FAIL push_timeout: pix_ready low for %0d cycles, required high", n);
        end
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    task automatic push_row(input logic sof, input logic idle);
        for (int k = 0; k < RP; k++) begin
            if (idle) while ($urandom_range(1, 0) == 1) tick();
            push(8'($urandom), sof && (k == 0));
        end
    endtask

    task automatic clear_stats();
        got_data.delete();
        got_idx.delete();
        fd_count   = 0;
        last_count = 0;
        saw_stall  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        clear_stats();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [RW-1:0] ev;
        int bad;
        clear_stats();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", pix_ready, 1);
        tick();

        // Single row of ramp pixels.
        row_ready = 1'b1;
        clear_stats();
        for (int k = 0; k < RP; k++) begin
            ev[k*BW +: BW] = 8'(k);
            push(8'(k), 1'b0);
        end
        @(negedge clk);
        chk("t1_latency_valid", row_valid, 1);
        chk("t1_row_idx", row_idx, 0);
        chk("t1_row_out", row_out, ev);
        tick();
        tick();
        chk("t1_no_stall", saw_stall, 0);
        chk("t1_rows", got_idx.size(), 1);
        if (got_data.size() == 1) chk("t1_data", got_data[0], ev);

        // Full frame plus one row of the next frame.
        do_reset();
        row_ready = 1'b1;
        for (int r = 0; r <= FR; r++) push_row(r == 0, 1'b0);
        repeat (3) tick();
        chk("t2_rows", got_idx.size(), FR + 1);
        if (got_idx.size() == FR + 1) begin
            bad = 0;
            for (int i = 0; i < FR; i++) if (got_idx[i] != i) bad++;
            chk("t2_order", bad, 0);
            chk("t2_wrap", got_idx[FR], 0);
        end
        chk("t2_last_count", last_count, 1);
        chk("t2_frame_done_count", fd_count, 1);

        // Backpressure with the consumer stalled.
        do_reset();
        row_ready = 1'b0;
        for (int r = 0; r < NBUF; r++) push_row(r == 0, 1'b0);
        @(negedge clk);
        chk("t3_ready_low", pix_ready, 0);
        chk("t3_valid", row_valid, 1);
        chk("t3_idx", row_idx, 0);
        repeat (4) tick();
        @(negedge clk);
        chk("t3_ready_still_low", pix_ready, 0);
        chk("t3_idx_held", row_idx, 0);
        tick();
        row_ready = 1'b1;
        @(negedge clk);
        chk("t3_ready_before_xfer", pix_ready, 0);
        tick();
        @(negedge clk);
        chk("t3_ready_after_xfer", pix_ready, 1);
        tick();
        push_row(1'b0, 1'b0);
        repeat (3) tick();
        chk("t3_rows", got_idx.size(), NBUF + 1);
        if (got_idx.size() == NBUF + 1) begin
            bad = 0;
            for (int i = 0; i <= NBUF; i++) if (got_idx[i] != i) bad++;
            chk("t3_order", bad, 0);
        end

        // SOF at column 35 of row 4.
        do_reset();
        row_ready = 1'b1;
        for (int r = 0; r < 4; r++) push_row(r == 0, 1'b0);
        for (int k = 0; k < 35; k++) push(8'($urandom), 1'b0);
        push(8'hA5, 1'b1);
        push(8'h5A, 1'b0);
        for (int k = 0; k < RP - 2; k++) push(8'($urandom), 1'b0);
        repeat (3) tick();
        chk("t4_sync_err", sync_err, 1);
        chk("t4_rows", got_idx.size(), 5);
        if (got_idx.size() == 5) begin
            chk("t4_row3_idx", got_idx[3], 3);
            chk("t4_resync_idx", got_idx[4], 0);
            chk("t4_byte0", got_data[4][7:0], 8'hA5);
            chk("t4_byte1", got_data[4][15:8], 8'h5A);
        end

        // Two frames with random gaps on both sides.
        do_reset();
        rand_rr = 1'b1;
        for (int r = 0; r < 2 * FR; r++) push_row(r == 0, 1'b1);
        rand_rr = 1'b0;
        row_ready = 1'b1;
        repeat (4) tick();
        chk("t5_rows", got_idx.size(), 2 * FR);
        chk("t5_pending", exp_q.size(), 0);
        if (got_idx.size() == 2 * FR) begin
            bad = 0;
            for (int i = 0; i < 2 * FR; i++) if (got_idx[i] != i % FR) bad++;
            chk("t5_order", bad, 0);
        end
        chk("t5_frame_done_count", fd_count, 2);
        chk("t5_sync_err", sync_err, 0);

        // Reset with a row pending and a partial row in progress.
        do_reset();
        row_ready = 1'b0;
        push_row(1'b1, 1'b0);
        if (NBUF == 2) for (int k = 0; k < 20; k++) push(8'($urandom), 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t6_row_valid", row_valid, 0);
        chk("t6_row_out", row_out, 0);
        chk("t6_row_idx", row_idx, 0);
        chk("t6_row_last", row_last, 0);
        chk("t6_frame_done", frame_done, 0);
        tick();
        tick();
        rst_n = 1'b1;
        row_ready = 1'b1;
        clear_stats();
        @(negedge clk);
        chk("t6_ready", pix_ready, 1);
        repeat (4) tick();
        chk("t6_no_rows", got_idx.size(), 0);
        chk("t6_no_frame_done", fd_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
